// File: rtl/obstacle_gen.sv
// obstacle_gen
// Cactus obstacle generator for the dinosaur game. Up to two ground obstacles
// are spawned and scrolled left once per video frame. Each obstacle is checked
// against the dinosaur's jump height, and obstacles that scroll off the left
// edge are counted as cleared.
//
// Ports:
//   CLK             system clock
//   clrn            asynchronous active-low reset
//   fresh           VGA vertical sync; rising edge marks a new frame (async to CLK)
//   game_status     1 = run requested, 0 = idle
//   speed           scroll distance in pixels per frame
//   row_addr        current VGA row
//   col_addr        current VGA column
//   dinosaur_height dinosaur feet height above ground, in pixels
//   px              registered flag: current pixel lies inside an active obstacle
//   collision       sticky hit flag, cleared on return to idle
//   score           obstacles cleared in the current run (saturating)
//
// Build option:
//   OBSTACLE_RANDOM_GAP_EN  when defined, spawn spacing is randomised by an LFSR;
//                           otherwise spacing is fixed at MIN_GAP + 64.

module obstacle_gen #(
    parameter int GROUND_ROW = 400,
    parameter int DINO_COL   = 80,
    parameter int DINO_W     = 40,
    parameter int CACTUS_W   = 16,
    parameter int CACTUS_H   = 32,
    parameter int MIN_GAP    = 160
) (
    input  logic        CLK,
    input  logic        clrn,
    input  logic        fresh,
    input  logic        game_status,
    input  logic [3:0]  speed,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic [5:0]  dinosaur_height,
    output logic        px,
    output logic        collision,
    output logic [15:0] score
);

    typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

    // Obstacles enter at the right edge of the 640-column screen.
    localparam logic [10:0] SPAWN_X    = 11'd640;
    localparam logic [10:0] DINO_LEFT  = 11'(DINO_COL);
    localparam logic [10:0] DINO_RIGHT = 11'(DINO_COL + DINO_W);
    localparam logic [10:0] CACTUS_W11 = 11'(CACTUS_W);
    localparam logic [10:0] ROW_TOP    = 11'(GROUND_ROW - CACTUS_H);
    localparam logic [10:0] ROW_BOTTOM = 11'(GROUND_ROW);
    localparam logic [5:0]  CACTUS_H6  = 6'(CACTUS_H);
    localparam logic [15:0] MIN_GAP16  = 16'(MIN_GAP);

    state_t      state;
    state_t      state_next;

    logic        fresh_s1;
    logic        fresh_s2;
    logic        fresh_prev;
    logic        tick;

    logic [1:0]  act;
    logic [10:0] x [2];
    logic [15:0] gap;

    logic [1:0]  act_next;
    logic [10:0] x_next [2];
    logic [15:0] gap_next;
    logic [15:0] score_next;
    logic [15:0] gap_reload;
    logic [1:0]  retired;
    logic [16:0] score_sum;
    logic        hit;
    logic        px_next;
    logic [10:0] speed11;
    logic [15:0] speed16;
    logic [10:0] row11;
    logic [10:0] col11;

    assign speed11 = {7'd0, speed};
    assign speed16 = {12'd0, speed};
    assign row11   = {2'd0, row_addr};
    assign col11   = {1'b0, col_addr};

    // fresh is asynchronous to CLK: two flops for metastability, a third
    // to find the rising edge, giving a single-cycle frame tick.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            fresh_s1   <= 1'b0;
            fresh_s2   <= 1'b0;
            fresh_prev <= 1'b0;
        end else begin
            fresh_s1   <= fresh;
            fresh_s2   <= fresh_s1;
            fresh_prev <= fresh_s2;
        end
    end

    assign tick = fresh_s2 & ~fresh_prev;

`ifdef OBSTACLE_RANDOM_GAP_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign gap_reload = MIN_GAP16 + {8'd0, lfsr[6:0], 1'b0};
`else
    assign gap_reload = MIN_GAP16 + 16'd64;
`endif

    // Hit test on the registered obstacle state against the dinosaur box.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (act[i] && (x[i] < DINO_RIGHT) && ((x[i] + CACTUS_W11) > DINO_LEFT)
                && (dinosaur_height < CACTUS_H6)) begin
                hit = 1'b1;
            end
        end
    end

    // Per-tick scroll. A slot retired on this tick counts as free, so a
    // pending spawn can reuse it immediately.
    always_comb begin
        act_next  = act;
        x_next[0] = x[0];
        x_next[1] = x[1];
        retired   = 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (act[i]) begin
                if (x[i] < speed11) begin
                    act_next[i] = 1'b0;
                    retired     = retired + 2'd1;
                end else begin
                    x_next[i] = x[i] - speed11;
                end
            end
        end

        gap_next = (gap < speed16) ? 16'd0 : (gap - speed16);

        if (gap == 16'd0) begin
            if (!act_next[0]) begin
                act_next[0] = 1'b1;
                x_next[0]   = SPAWN_X;
                gap_next    = gap_reload;
            end else if (!act_next[1]) begin
                act_next[1] = 1'b1;
                x_next[1]   = SPAWN_X;
                gap_next    = gap_reload;
            end
        end

        score_sum  = {1'b0, score} + {15'd0, retired};
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving RUN for IDLE takes priority over a hit in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (game_status) state_next = RUN;
            RUN: begin
                if (!game_status) begin
                    state_next = IDLE;
                end else if (hit) begin
                    state_next = HIT;
                end
            end
            HIT: if (!game_status) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Obstacle slots, spacing counter, score and collision flag. Ticks are
    // only acted on while staying in RUN, so a tick on either RUN boundary
    // is dropped. x is left untouched in IDLE; only act matters there.
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            act       <= 2'b00;
            x[0]      <= 11'd0;
            x[1]      <= 11'd0;
            gap       <= MIN_GAP16;
            collision <= 1'b0;
            score     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    act       <= 2'b00;
                    gap       <= MIN_GAP16;
                    collision <= 1'b0;
                    if (game_status) begin
                        score <= 16'd0;
                    end
                end
                RUN: begin
                    if (game_status) begin
                        if (tick) begin
                            act   <= act_next;
                            x[0]  <= x_next[0];
                            x[1]  <= x_next[1];
                            gap   <= gap_next;
                            score <= score_next;
                        end
                        if (hit) begin
                            collision <= 1'b1;
                        end
                    end
                end
                HIT: begin
                    collision <= 1'b1;
                end
                default: begin
                    act <= 2'b00;
                end
            endcase
        end
    end

    // Pixel flag, one cycle behind the scan address; suppressed in IDLE.
    always_comb begin
        px_next = 1'b0;
        if ((state != IDLE) && (row11 >= ROW_TOP) && (row11 < ROW_BOTTOM)) begin
            for (int i = 0; i < 2; i++) begin
                if (act[i] && (col11 >= x[i]) && (col11 < (x[i] + CACTUS_W11))) begin
                    px_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            px <= 1'b0;
        end else begin
            px <= px_next;
        end
    end

endmodule
